dmem_responder: RTL

Data-memory responder serving the processor's load/store port over a req/ack handshake with programmable wait states, byte enables and registered read data. It replaces the single-cycle data memory when slower storage must be modelled. It sits between the datapath's ALU-result/RD2 outputs and the write-back mux input.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Load/store data memory behind a req/ack handshake with WAIT_STATES wait cycles and byte enables.
// Optional macro DMEM_ERR_EN: flag misaligned/out-of-range accesses with err and skip them.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("dmem_responder: WAIT_STATES must be 0..15");
  end
  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 4");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state, nxt;
  logic [3:0]     cnt;
  logic           we_q;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wdata_q;
  logic [3:0]     be_q;
  logic           fault_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic           fault_in;
  logic           capture;
  logic           acc;
  logic           acc_we;
  logic [AW-1:0]  acc_idx;
  logic [31:0]    acc_wdata;
  logic [3:0]     acc_be;

`ifdef DMEM_ERR_EN
  assign fault_in = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[1:0], addr[31:AW+2]};
  assign fault_in = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt     = state;
    capture = 1'b0;
    acc     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (fault_in || WAIT_STATES == 0) nxt = RESP;
          else                              nxt = WAIT;
          // zero wait states: the access itself happens on the capture edge
          if (!fault_in && WAIT_STATES == 0) acc = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          acc = 1'b1;
          nxt = RESP;
        end
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // In IDLE the access uses the live request, otherwise the captured one.
  always_comb begin
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state == IDLE) begin
      acc_we    = we;
      acc_idx   = addr[AW+1:2];
      acc_wdata = wdata;
      acc_be    = be;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt     <= 4'd0;
      rdata   <= 32'h0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      fault_q <= 1'b0;
    end else begin
      if (capture) begin
        we_q    <= we;
        idx_q   <= addr[AW+1:2];
        wdata_q <= wdata;
        be_q    <= be;
        fault_q <= fault_in;
        cnt     <= WS4;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (acc && !acc_we) rdata <= mem[acc_idx];
    end
  end

  // Storage is never reset; RST only blocks the write.
  always_ff @(posedge CLK) begin
    if (RST && acc && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign busy = (state != IDLE);
  assign ack  = (state == RESP) && RST;
  assign err  = ack && fault_q;

endmodule
